// File: rtl/alu_share_sched.sv
// alu_share_sched: round-robin scheduler sharing one add_sub unit between
// NREQ requesters. One operation is in flight at a time. It is granted in
// IDLE, executed from latched operands in EXEC, and returned in RESP.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_op, req_a, req_b  per-requester operation and 3-bit sign-magnitude operands
//   rsp_valid/rsp_ready   response handshake
//   rsp_id, rsp_r         issuing requester index and 4-bit sign-magnitude result
//   rsp_sf, rsp_zf        sign flag and zero flag of the result
//   busy                  registered, high whenever the FSM is not in IDLE
//   op_count              count of accepted responses, wraps at 256
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | arbitrate; grant the first valid requester at or after ptr
// EXEC  | add_sub evaluates the latched operands; capture the result
// RESP  | present the response and hold it until rsp_ready

// add_sub: sign-magnitude A+B (op=0) or A-B (op=1) on 3-bit operands.
// A negative zero operand is treated as zero. A zero result is always +0.
module add_sub (
  input  logic       op,
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic [3:0] r,
  output logic       sf,
  output logic       zf
);
  logic signed [3:0] va, vb, sum;
  logic [3:0] mag;

  always_comb begin
    va  = a[2] ? -$signed({2'b00, a[1:0]}) : $signed({2'b00, a[1:0]});
    vb  = b[2] ? -$signed({2'b00, b[1:0]}) : $signed({2'b00, b[1:0]});
    sum = op ? (va - vb) : (va + vb);
    // Range is -6..+6, so the 4-bit two's complement never overflows.
    mag = sum[3] ? $unsigned(-sum) : $unsigned(sum);
    r   = {sum[3], mag[2:0]};
    sf  = sum[3];
    zf  = (mag[2:0] == 3'd0);
  end
endmodule

module alu_share_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_op,
  input  logic [3*NREQ-1:0] req_a,
  input  logic [3*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [3:0]        rsp_r,
  output logic              rsp_sf,
  output logic              rsp_zf,
  output logic              busy,
  output logic [7:0]        op_count
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t state, state_next;

  logic [IDW-1:0]    ptr, ptr_next, win;
  logic              found, grant;
  logic [2*NREQ-1:0] rot_full;
  logic [NREQ-1:0]   rot;
  int                win_i;

  logic              sel_op;
  logic [2:0]        sel_a, sel_b;

  logic              lat_op;
  logic [2:0]        lat_a, lat_b;
  logic [IDW-1:0]    lat_id;

  logic [3:0]        as_r;
  logic              as_sf, as_zf;

  // Rotate the request vector so bit 0 is the requester at ptr, then take
  // the first set bit; that is the round-robin winner.
  always_comb begin
    rot_full = {req_valid, req_valid} >> ptr;
    rot      = rot_full[NREQ-1:0];
    found    = 1'b0;
    win_i    = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        win_i = (int'(ptr) + i) % NREQ;
      end
    end
    win   = IDW'(win_i);
    grant = found && (state == S_IDLE);
    if (win_i == NREQ - 1) ptr_next = '0;
    else                   ptr_next = win + 1'b1;
  end

  always_comb begin
    sel_op = 1'b0;
    sel_a  = 3'd0;
    sel_b  = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        sel_op = req_op[i];
        sel_a  = req_a[3*i +: 3];
        sel_b  = req_b[3*i +: 3];
      end
    end
  end

  // The arithmetic unit only ever sees the latched operands.
  add_sub u_add_sub (
    .op (lat_op),
    .a  (lat_a),
    .b  (lat_b),
    .r  (as_r),
    .sf (as_sf),
    .zf (as_zf)
  );

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ptr      <= '0;
      busy     <= 1'b0;
      lat_op   <= 1'b0;
      lat_a    <= 3'd0;
      lat_b    <= 3'd0;
      lat_id   <= '0;
      rsp_id   <= '0;
      rsp_r    <= 4'd0;
      rsp_sf   <= 1'b0;
      rsp_zf   <= 1'b0;
      op_count <= 8'd0;
    end else begin
      state <= state_next;
      busy  <= (state_next != S_IDLE);
      if (grant) begin
        lat_op <= sel_op;
        lat_a  <= sel_a;
        lat_b  <= sel_b;
        lat_id <= win;
        ptr    <= ptr_next;
      end
      if (state == S_EXEC) begin
        rsp_r  <= as_r;
        rsp_sf <= as_sf;
        rsp_zf <= as_zf;
        rsp_id <= lat_id;
      end
      if (state == S_RESP && rsp_ready) op_count <= op_count + 8'd1;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (grant) state_next = S_EXEC;
      S_EXEC:  state_next = S_RESP;
      S_RESP:  if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs; a grant is never shown while reset is asserted.
  always_comb begin
    rsp_valid = (state == S_RESP);
    req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      req_ready[i] = grant && rst_n && (win == IDW'(i));
  end
endmodule

// File: doc/alu_share_sched.md
# alu_share_sched

Round-robin scheduler that shares a single `add_sub` 3-bit sign-magnitude add/subtract unit between `NREQ` requesters. It instantiates `add_sub` internally and accepts one operation at a time over per-requester valid/ready handshakes. It registers the operands, executes the operation, and returns the 4-bit result, SF, ZF and the requester ID on a single response channel. It sits between client blocks and the shared arithmetic datapath.

## Interface
- `NREQ`, default 4, number of requesters (2..8).
- `IDW`, default 2, width of requester ID; must satisfy 2^IDW >= NREQ.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req_valid`  in  NREQ  bit i: requester i has an operation pending.
- `req_ready`  out  NREQ  bit i: requester i granted this cycle (one-hot or zero).
- `req_op`  in  NREQ  bit i: OP of requester i (0 = A+B, 1 = A−B).
- `req_a`  in  3*NREQ  slice [3i+2:3i]: operand A of requester i, sign-magnitude (bit2 sign, bits1:0 magnitude).
- `req_b`  in  3*NREQ  slice [3i+2:3i]: operand B of requester i, same format.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_id`  out  IDW  index of the requester that issued the operation.
- `rsp_r`  out  4  result, sign-magnitude (bit3 sign, bits2:0 magnitude).
- `rsp_sf`  out  1  sign flag (equals `rsp_r[3]`).
- `rsp_zf`  out  1  zero flag (magnitude == 0).
- `busy`  out  1  high in any state other than IDLE.
- `op_count`  out  8  completed-response counter.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` is high, grant the first set bit, searching from `ptr` upward modulo NREQ.
  - `req_ready` is driven combinationally, only for that winner.
  - On the handshake, latch op/a/b/id, set `ptr` to (winner+1) mod NREQ, and go to EXEC.
  - If no request is pending, stay in IDLE.
- EXEC:
  - `add_sub` is driven from the latched registers only, never from live `req_*` inputs.
  - Capture R, SF and ZF into the response registers, then go to RESP.
- RESP:
  - Assert `rsp_valid`. Hold `rsp_id`/`rsp_r`/`rsp_sf`/`rsp_zf` stable until `rsp_ready`.
  - On `rsp_valid & rsp_ready`: increment `op_count` (255 wraps to 0) and go to IDLE.
- `req_ready` is all zeros outside IDLE.
- A requester must hold its valid and operands stable until granted. Dropping `req_valid` before grant withdraws the request, with no side effect.
- `ptr` changes only on a grant. A lone requester is granted repeatedly.
- Arithmetic is fully defined by `add_sub`:
  - A zero result always has SF=0 and `rsp_r` = 4'b0000.
  - Result magnitude spans 0..6.
- Reset (`rst_n` low at a clock edge), from any state including mid-operation:
  - State = IDLE, `ptr` = 0, `op_count` = 0.
  - `rsp_valid` = 0 and `rsp_r`/`rsp_id`/`rsp_sf`/`rsp_zf` = 0.
  - `busy` = 0.
  - The in-flight operation is discarded and never responded.
- While `rst_n` is low, `req_ready` = 0.

## Timing
- Grant at cycle T (handshake). EXEC at T+1. `rsp_valid` is high from T+2.
- Minimum latency, handshake to response: 2 cycles.
- Response accepted at cycle U → IDLE at U+1. The earliest next grant is at U+1.
- Peak throughput: 1 operation per 3 cycles.
- `rsp_ready` held low stalls the block in RESP indefinitely. No new grants occur during the stall.
- `busy` is registered and equals (state != IDLE).

## Test plan
- **Single add.** Stimulus: requester 0 sends OP=0, A=3'b010, B=3'b011, `rsp_ready`=1. Required: `rsp_valid` 2 cycles after the grant, `rsp_r`=4'b0101, SF=0, ZF=0, `rsp_id`=0, `op_count`=1.
- **Negative and zero results.** Stimulus: requester 2 sends OP=1, A=3'b001, B=3'b011. Required: `rsp_r`=4'b1010, SF=1. Stimulus: OP=0, A=3'b111, B=3'b111. Required: 4'b1110. Stimulus: OP=1, A=B=3'b010. Required: 4'b0000, ZF=1, SF=0.
- **Round-robin fairness.** Stimulus: all 4 requesters valid continuously after reset. Required: grant order 0,1,2,3,0; each `rsp_id` matches; each grant is exactly 3 cycles apart with `rsp_ready`=1.
- **Backpressure.** Stimulus: `rsp_ready`=0 for 5 cycles in RESP. Required: outputs stable, `req_ready`=0, `busy`=1 throughout. Then raise `rsp_ready`: IDLE on the next cycle, `op_count` increments once.
- **Reset mid-operation.** Stimulus: assert `rst_n`=0 in EXEC. Required: next cycle `rsp_valid`=0, `busy`=0, `op_count`=0, `ptr`=0. No response is ever issued for the dropped operation. The first grant after reset goes to the lowest valid index.
- **Counter wrap.** Stimulus: 256 completed operations. Required: `op_count` reads 0 after the 256th accepted response.
